// File: rtl/sync_bus_edge.sv
// Multi-channel level synchroniser with registered per-channel rise/fall pulses and an any-change flag.
// Optional glitch filter enabled by defining SYNC_BUS_EDGE_GLITCH_FILTER_EN.
module sync_bus_edge #(
    parameter int unsigned      WIDTH      = 1,
    parameter int unsigned      STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}},
    parameter int unsigned      FILTER_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_change
);

    // Reject illegal configurations at elaboration
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_bus_edge: STAGES must be in 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 256) begin : g_bad_filter
        $error("sync_bus_edge: FILTER_LEN must be in 1..256");
    end

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_r [STAGES];

    logic [WIDTH-1:0] lvl;
    logic [WIDTH-1:0] next_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                sync_r[k] <= RESET_VAL;
            end
        end else begin
            sync_r[0] <= async_in;
            for (int unsigned k = 1; k < STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
        end
    end

    assign lvl = sync_r[STAGES-1];

`ifdef SYNC_BUS_EDGE_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

    logic [CNT_W-1:0] cnt      [WIDTH];
    logic [CNT_W-1:0] next_cnt [WIDTH];

    // A differing level must persist FILTER_LEN cycles before it replaces sync_out
    always_comb begin
        next_q = sync_out;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            next_cnt[i] = cnt[i];
            if (lvl[i] == sync_out[i]) begin
                next_cnt[i] = '0;
            end else if (cnt[i] == CNT_W'(FILTER_LEN - 1)) begin
                next_q[i]   = lvl[i];
                next_cnt[i] = '0;
            end else begin
                next_cnt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= next_cnt[i];
            end
        end
    end
`else
    always_comb begin
        next_q = lvl;
    end
`endif

    // Pulses are registered alongside sync_out so both appear in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_out   <= RESET_VAL;
            rise_pulse <= '0;
            fall_pulse <= '0;
            any_change <= 1'b0;
        end else begin
            sync_out   <= next_q;
            rise_pulse <= ~sync_out & next_q;
            fall_pulse <= sync_out & ~next_q;
            any_change <= |(sync_out ^ next_q);
        end
    end

endmodule

// File: tb/tb_sync_bus_edge.sv
// Directed self-checking bench for sync_bus_edge: latency, pulses, reset and (optionally) glitch filtering.
module tb_sync_bus_edge;

    logic       clk;
    logic       rst_n;
    logic       a1;
    logic       q1, r1, f1, c1;
    logic [3:0] a4;
    logic [3:0] q4, r4, f4;
    logic       c4;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FILTER_LEN=1 keeps these instances cycle-identical in both builds
    sync_bus_edge #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0), .FILTER_LEN(1)) u1 (
        .clk(clk), .rst_n(rst_n), .async_in(a1), .sync_out(q1),
        .rise_pulse(r1), .fall_pulse(f1), .any_change(c1)
    );

    sync_bus_edge #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'b0000), .FILTER_LEN(1)) u4 (
        .clk(clk), .rst_n(rst_n), .async_in(a4), .sync_out(q4),
        .rise_pulse(r4), .fall_pulse(f4), .any_change(c4)
    );

`ifdef SYNC_BUS_EDGE_GLITCH_FILTER_EN
    logic af, qf, rf, ff, cf;

    sync_bus_edge #(.WIDTH(1), .STAGES(2), .RESET_VAL(1'b0), .FILTER_LEN(4)) uf (
        .clk(clk), .rst_n(rst_n), .async_in(af), .sync_out(qf),
        .rise_pulse(rf), .fall_pulse(ff), .any_change(cf)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b0;
        a4 = 4'b0000;
`ifdef SYNC_BUS_EDGE_GLITCH_FILTER_EN
        af = 1'b0;
`endif
        repeat (2) tick();
        checks++; if (q1 !== 1'b0) begin failures++; $display("FAIL reset_q1 got=%0b exp=0", q1); end
        checks++; if ({r1, f1, c1} !== 3'b000) begin failures++; $display("FAIL reset_pulses1 got=%b exp=000", {r1, f1, c1}); end
        checks++; if (q4 !== 4'b0000) begin failures++; $display("FAIL reset_q4 got=%b exp=0000", q4); end
        checks++; if ({r4, f4, c4} !== 9'b0) begin failures++; $display("FAIL reset_pulses4 got=%b exp=0", {r4, f4, c4}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++; if (q1 !== 1'b0) begin failures++; $display("FAIL post_reset_q1 got=%0b exp=0", q1); end
    endtask

    task automatic test_rise_fall();
        a1 = 1'b1;
        tick();
        tick();
        checks++; if ({q1, r1} !== 2'b00) begin failures++; $display("FAIL rise_early got=%b exp=00", {q1, r1}); end
        tick();
        checks++; if ({q1, r1, f1, c1} !== 4'b1101) begin failures++; $display("FAIL rise_edge3 got=%b exp=1101", {q1, r1, f1, c1}); end
        tick();
        checks++; if ({q1, r1, c1} !== 3'b100) begin failures++; $display("FAIL rise_width got=%b exp=100", {q1, r1, c1}); end
        a1 = 1'b0;
        tick();
        tick();
        checks++; if ({q1, f1} !== 2'b10) begin failures++; $display("FAIL fall_early got=%b exp=10", {q1, f1}); end
        tick();
        checks++; if ({q1, r1, f1, c1} !== 4'b0011) begin failures++; $display("FAIL fall_edge3 got=%b exp=0011", {q1, r1, f1, c1}); end
        tick();
        checks++; if ({f1, c1} !== 2'b00) begin failures++; $display("FAIL fall_width got=%b exp=00", {f1, c1}); end
    endtask

    task automatic test_multi_channel();
        a4 = 4'b1010;
        repeat (3) tick();
        checks++; if ({r4, c4} !== 5'b00000) begin failures++; $display("FAIL multi_early got=%b exp=00000", {r4, c4}); end
        tick();
        checks++; if (r4 !== 4'b1010) begin failures++; $display("FAIL multi_rise got=%b exp=1010", r4); end
        checks++; if ({f4, c4, q4} !== 9'b0000_1_1010) begin failures++; $display("FAIL multi_misc got=%b exp=000011010", {f4, c4, q4}); end
        tick();
        checks++; if ({r4, c4} !== 5'b00000) begin failures++; $display("FAIL multi_width got=%b exp=00000", {r4, c4}); end
    endtask

    task automatic test_reset_mid();
        a1 = 1'b1;
        repeat (3) tick();
        checks++; if ({q1, r1} !== 2'b11) begin failures++; $display("FAIL mid_setup got=%b exp=11", {q1, r1}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({q1, r1, f1, c1} !== 4'b0000) begin failures++; $display("FAIL mid_async1 got=%b exp=0000", {q1, r1, f1, c1}); end
        checks++; if ({q4, r4, c4} !== 9'b0) begin failures++; $display("FAIL mid_async4 got=%b exp=0", {q4, r4, c4}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if ({q1, r1} !== 2'b00) begin failures++; $display("FAIL mid_release_early got=%b exp=00", {q1, r1}); end
        tick();
        checks++; if ({q1, r1, c1} !== 3'b111) begin failures++; $display("FAIL mid_release_rise got=%b exp=111", {q1, r1, c1}); end
        tick();
    endtask

    task automatic test_toggle();
        logic s0, s1, qm, nq, er, ef;
        int   nt, np;
        s0 = 1'b1; s1 = 1'b1; qm = 1'b1;
        nt = 0; np = 0;
        for (int c = 0; c < 36; c++) begin
            if (c % 3 == 0 && c < 30) begin
                a1 = ~a1;
                nt++;
            end
            tick();
            nq = s1;
            s1 = s0;
            s0 = a1;
            er = nq & ~qm;
            ef = ~nq & qm;
            qm = nq;
            checks++; if ({q1, r1, f1} !== {nq, er, ef}) begin failures++; $display("FAIL toggle_c%0d got=%b exp=%b", c, {q1, r1, f1}, {nq, er, ef}); end
            np += int'(r1) + int'(f1);
        end
        checks++; if (np !== nt) begin failures++; $display("FAIL toggle_count got=%0d exp=%0d", np, nt); end
    endtask

`ifdef SYNC_BUS_EDGE_GLITCH_FILTER_EN
    task automatic test_filter_glitch();
        af = 1'b1;
        repeat (3) tick();
        af = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if ({qf, rf, cf} !== 3'b000) begin failures++; $display("FAIL glitch_k%0d got=%b exp=000", k, {qf, rf, cf}); end
        end
    endtask

    task automatic test_filter_accept();
        af = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if ({qf, rf} !== 2'b00) begin failures++; $display("FAIL accept_early_k%0d got=%b exp=00", k, {qf, rf}); end
        end
        tick();
        checks++; if ({qf, rf, cf} !== 3'b111) begin failures++; $display("FAIL accept_edge6 got=%b exp=111", {qf, rf, cf}); end
        tick();
        checks++; if ({qf, rf} !== 2'b10) begin failures++; $display("FAIL accept_width got=%b exp=10", {qf, rf}); end
    endtask

    task automatic test_filter_restart();
        int nr;
        logic eq, er;
        af = 1'b0;
        repeat (10) tick();
        checks++; if (qf !== 1'b0) begin failures++; $display("FAIL restart_setup got=%0b exp=0", qf); end
        nr = 0;
        for (int k = 1; k <= 12; k++) begin
            af = (k == 4) ? 1'b0 : 1'b1;
            tick();
            eq = (k >= 10);
            er = (k == 10);
            checks++; if ({qf, rf} !== {eq, er}) begin failures++; $display("FAIL restart_k%0d got=%b exp=%b", k, {qf, rf}, {eq, er}); end
            nr += int'(rf);
        end
        checks++; if (nr !== 1) begin failures++; $display("FAIL restart_count got=%0d exp=1", nr); end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_rise_fall();
        test_multi_channel();
        test_reset_mid();
        test_toggle();
`ifdef SYNC_BUS_EDGE_GLITCH_FILTER_EN
        test_filter_glitch();
        test_filter_accept();
        test_filter_restart();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_bus_edge.md
Name: sync_bus_edge

Overview:
- Parametrised, multi-channel successor to the two-flop single-bit synchroniser.
- Brings WIDTH independent asynchronous level signals (link status, PHY lock, SW control bits) into the `clk` domain through a STAGES-deep flop chain.
- Registers the synchronised level and emits single-cycle rise/fall pulses per channel, plus an any-change flag.
- An optional per-channel stability filter rejects glitches shorter than FILTER_LEN cycles.

Parameters:
- WIDTH, 1: number of independent channels.
- STAGES, 2: synchroniser depth; legal range 2..4; values outside the range are a compile-time error.
- RESET_VAL, {WIDTH{1'b0}}: reset value of every chain stage and of sync_out.
- FILTER_LEN, 4: consecutive cycles a new level must hold before acceptance. Used only with GLITCH_FILTER_EN. Legal range 1..256.

Ports:
- clk  input  1  destination clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk externally.
- async_in  input  WIDTH  asynchronous level inputs; each bit is independent; no bus coherency is implied.
- sync_out  output  WIDTH  registered synchronised (and optionally filtered) levels.
- rise_pulse  output  WIDTH  one-cycle pulse when sync_out[i] goes 0->1.
- fall_pulse  output  WIDTH  one-cycle pulse when sync_out[i] goes 1->0.
- any_change  output  1  OR of (rise_pulse | fall_pulse); registered; coincident with the pulses.

Behaviour:
- Chain: per channel, sync_r[0] <= async_in[i]; sync_r[k] <= sync_r[k-1]. The last stage is `lvl`.
- Output register q (= sync_out), unfiltered build: q <= lvl every cycle.
- Pulse generation is registered and asserted in the same cycle sync_out shows the new value:
  - rise_pulse[i] <= ~q[i] & next_q[i]
  - fall_pulse[i] <= q[i] & ~next_q[i]
  - any_change <= |(rise | fall)
- Pulses are exactly 1 cycle wide. A level that toggles every cycle at lvl produces alternating rise/fall pulses; none are merged or dropped.
- Latency, unfiltered: input stable before edge 1 -> sync_r[0] updates at edge 1 -> lvl at edge STAGES -> sync_out and the pulse are visible after edge STAGES+1.
- Reset (rst_n=0), immediate and asynchronous, also mid-operation:
  - all chain stages and sync_out = RESET_VAL
  - rise_pulse = fall_pulse = 0, any_change = 0
  - filter counters = 0
- After reset release, an input differing from RESET_VAL propagates normally and produces its edge pulse after STAGES+1 edges. This is intentional: the consumer sees the true initial state as an event.
- Channels never interact. Simultaneous edges on several channels give simultaneous pulses and a single-cycle any_change.
- No combinational path from async_in to any output.
- All chain flops carry the ASYNC_REG attribute.

Optional Feature:
- Macro: SYNC_BUS_EDGE_GLITCH_FILTER_EN
- Defined:
  - Each channel has a counter cnt of $clog2(FILTER_LEN+1) bits.
  - If lvl == q: cnt <= 0.
  - Else if cnt == FILTER_LEN-1: q <= lvl, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A new level is accepted after FILTER_LEN consecutive differing cycles, giving latency STAGES+FILTER_LEN edges.
  - A lvl excursion shorter than FILTER_LEN cycles leaves sync_out unchanged and produces no pulse.
  - FILTER_LEN=1 is cycle-identical to the undefined build.
- Undefined: no counters; the unfiltered path applies and FILTER_LEN is ignored.

Test Plan:
- WIDTH=1, STAGES=2: async_in 0->1 set up before edge 1 -> sync_out=1 and rise_pulse=1 for exactly one cycle after edge 3; then 1->0 -> fall_pulse one cycle, 3 edges later.
- WIDTH=4, STAGES=3: async_in 4'b0000->4'b1010 -> after edge 4, rise_pulse=4'b1010 and any_change=1 for one cycle; fall_pulse=0.
- Reset mid-operation: sync_out=1 and a pulse in flight, pull rst_n low between edges -> sync_out=RESET_VAL(0) and pulses 0 immediately. Release with async_in=1 -> rise_pulse after STAGES+1 edges.
- Filter on, FILTER_LEN=4, STAGES=2: 3-cycle high glitch -> no pulse, sync_out stays 0. A 4-cycle high level -> sync_out=1 and rise_pulse after edge 6 from input change.
- Filter on: high level held 3 cycles, 1 low cycle, then held -> counter restarts; acceptance 4 cycles after the restart, with a single rise pulse.
- Toggle async_in every 3 cycles, unfiltered, WIDTH=1 -> every transition yields exactly one pulse of the correct polarity, delayed by 3 edges; pulse count equals transition count.
